prog_loader: RTL and testbench

Program-memory loader for the 16-bit stack CPU. It is the writer side of the program store: the CPU core only reads 18-bit instruction words. This block receives a framed byte stream, assembles 18-bit instruction words, and writes them to consecutive program-memory addresses starting at 0. It holds the CPU until a load completes with a valid checksum.

---
 rtl/prog_loader.sv | 86 ++++++++
 tb/tb_prog_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: turns a framed byte stream into 18-bit program words and holds the CPU
// until the whole frame has been loaded with a matching XOR checksum.
module prog_loader #(
   parameter int ADDR_W = 16
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic [7:0]        i_byte,
   input  logic              i_byteValid,
   output logic              o_byteReady,
   output logic [ADDR_W-1:0] o_wAddr,
   output logic [0:17]       o_wData,
   output logic              o_wEn,
   output logic              o_cpuHold,
   output logic              o_done,
   output logic              o_error,
   output logic [ADDR_W-1:0] o_count
);
   typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2, WRITE, CSUM, DONE, ERROR} state_t;
   state_t state, nxt;
   logic acc;
   logic [7:0] len_hi, csum, b1;
   logic [1:0] b0;
   logic [ADDR_W-1:0] addr, len;
   assign acc = i_byteValid && o_byteReady;
   always_comb begin
      nxt = state;
      case (state)
         IDLE, DONE, ERROR: nxt = i_start ? LEN_HI : state;
         LEN_HI: nxt = acc ? LEN_LO : state;
         LEN_LO: nxt = !acc ? state : ({len_hi, i_byte} == 16'd0) ? CSUM : BYTE0;
         BYTE0: nxt = !acc ? state : (i_byte[7:2] != 6'd0) ? ERROR : BYTE1;
         BYTE1: nxt = acc ? BYTE2 : state;
         BYTE2: nxt = acc ? WRITE : state;
         WRITE: nxt = (o_count + ADDR_W'(1) == len) ? CSUM : BYTE0;
         CSUM: nxt = !acc ? state : (i_byte == csum) ? DONE : ERROR;
         default: nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state <= IDLE;
         o_byteReady <= 1'b0;
         o_wEn <= 1'b0;
         o_wAddr <= '0;
         o_wData <= '0;
         o_count <= '0;
         o_done <= 1'b0;
         o_error <= 1'b0;
         o_cpuHold <= 1'b1;
         addr <= '0;
         len <= '0;
         len_hi <= '0;
         csum <= '0;
         b0 <= '0;
         b1 <= '0;
      end else begin
         state <= nxt;
         o_byteReady <= nxt inside {LEN_HI, LEN_LO, BYTE0, BYTE1, BYTE2, CSUM};
         o_wEn <= nxt == WRITE;
         o_done <= nxt == DONE;
         o_error <= nxt == ERROR;
         o_cpuHold <= nxt != DONE;
         if (state inside {IDLE, DONE, ERROR} && i_start) begin
            addr <= '0;
            o_count <= '0;
            csum <= '0;
         end
         if (acc && state != CSUM) csum <= csum ^ i_byte;
         if (acc && state == LEN_HI) len_hi <= i_byte;
         if (acc && state == LEN_LO) len <= ADDR_W'({len_hi, i_byte});
         if (acc && state == BYTE0) b0 <= i_byte[1:0];
         if (acc && state == BYTE1) b1 <= i_byte;
         if (acc && state == BYTE2) begin
            o_wAddr <= addr;
            o_wData <= {b0, b1, i_byte};
         end
         if (state == WRITE) begin
            addr <= addr + ADDR_W'(1);
            o_count <= o_count + ADDR_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table-driven frame loads plus hand-written stall, restart and reset sequences.
module tb_prog_loader;
   logic i_clock = 1'b0;
   logic i_reset, i_start, i_byteValid;
   logic [7:0] i_byte;
   logic o_byteReady, o_wEn, o_cpuHold, o_done, o_error;
   logic [15:0] o_wAddr, o_count;
   logic [0:17] o_wData;
   int total = 0, bad = 0;
   logic [15:0] wa[256];
   logic [17:0] wd[256];
   int nwr = 0;

   typedef struct {
      int n;
      logic [159:0] bytes;
      int nw;
      logic [107:0] words;
      logic done;
      logic err;
      int cnt;
      bit gap;
   } vec_t;
   vec_t vec[6];

   prog_loader #(.ADDR_W(16)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_byte(i_byte),
      .i_byteValid(i_byteValid), .o_byteReady(o_byteReady), .o_wAddr(o_wAddr),
      .o_wData(o_wData), .o_wEn(o_wEn), .o_cpuHold(o_cpuHold), .o_done(o_done),
      .o_error(o_error), .o_count(o_count)
   );

   always #5 i_clock = ~i_clock;

   always @(negedge i_clock) if (o_wEn && nwr < 256) begin
      wa[nwr] = o_wAddr;
      wd[nwr] = o_wData;
      nwr++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int k = 0;
      i_byte = b;
      i_byteValid = 1'b1;
      while (!o_byteReady && k < 20) begin
         @(negedge i_clock);
         k++;
      end
      if (!o_byteReady) chk("send_timeout", 32'd1, 32'd0);
      else @(negedge i_clock);
      i_byteValid = 1'b0;
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge i_clock);
      i_start = 1'b0;
   endtask

   initial begin
      int base;
      vec[0] = '{9, 160'h000203FFFF00123427, 2, {18'h3FFFF, 18'h01234}, 1'b1, 1'b0, 2, 1'b0};
      vec[1] = '{3, 160'h000000, 0, 108'h0, 1'b1, 1'b0, 0, 1'b0};
      vec[2] = '{9, 160'h000203FFFF00123428, 2, {18'h3FFFF, 18'h01234}, 1'b0, 1'b1, 2, 1'b0};
      vec[3] = '{3, 160'h000104, 0, 108'h0, 1'b0, 1'b1, 0, 1'b0};
      vec[4] = '{18, 160'h0005_010001_02ABCD_000000_031234_01FF00_BA, 5,
                 {18'h10001, 18'h2ABCD, 18'h00000, 18'h31234, 18'h1FF00}, 1'b1, 1'b0, 5, 1'b0};
      vec[5] = vec[4];
      vec[5].gap = 1'b1;

      i_reset = 1'b1; i_start = 1'b0; i_byteValid = 1'b0; i_byte = 8'h00;
      repeat (2) @(negedge i_clock);
      i_reset = 1'b0;
      base = nwr;
      repeat (10) @(negedge i_clock);
      chk("rst_writes", nwr - base, 0);
      chk("rst_hold", o_cpuHold, 1);
      chk("rst_ready", o_byteReady, 0);
      chk("rst_waddr", o_wAddr, 0);
      chk("rst_wdata", o_wData, 0);
      chk("rst_count", o_count, 0);
      chk("rst_done", o_done, 0);
      chk("rst_error", o_error, 0);

      for (int v = 0; v < 6; v++) begin
         pulse_start();
         chk($sformatf("v%0d_start_err", v), o_error, 0);
         chk($sformatf("v%0d_start_done", v), o_done, 0);
         chk($sformatf("v%0d_start_cnt", v), o_count, 0);
         chk($sformatf("v%0d_start_hold", v), o_cpuHold, 1);
         chk($sformatf("v%0d_start_ready", v), o_byteReady, 1);
         base = nwr;
         for (int i = 0; i < vec[v].n; i++) begin
            if (vec[v].gap) begin
               i_byte = 8'h5A;
               repeat ($urandom_range(0, 3)) @(negedge i_clock);
            end
            send(vec[v].bytes[8*(vec[v].n-1-i) +: 8]);
         end
         repeat (3) @(negedge i_clock);
         chk($sformatf("v%0d_nwrites", v), nwr - base, vec[v].nw);
         for (int j = 0; j < vec[v].nw; j++) begin
            chk($sformatf("v%0d_addr%0d", v, j), wa[base+j], j);
            chk($sformatf("v%0d_data%0d", v, j), wd[base+j], vec[v].words[18*(vec[v].nw-1-j) +: 18]);
         end
         chk($sformatf("v%0d_done", v), o_done, vec[v].done);
         chk($sformatf("v%0d_error", v), o_error, vec[v].err);
         chk($sformatf("v%0d_count", v), o_count, vec[v].cnt);
         chk($sformatf("v%0d_hold", v), o_cpuHold, !vec[v].done);
         chk($sformatf("v%0d_ready", v), o_byteReady, 0);
      end

      // start pulsed in BYTE1 must not restart the frame
      pulse_start();
      base = nwr;
      send(8'h00); send(8'h01); send(8'h02);
      i_start = 1'b1;
      @(negedge i_clock);
      i_start = 1'b0;
      chk("mid_start_ready", o_byteReady, 1);
      send(8'hAB); send(8'hCD);
      chk("mid_wen", o_wEn, 1);
      chk("mid_wen_ready", o_byteReady, 0);
      chk("mid_waddr", o_wAddr, 0);
      chk("mid_wdata", o_wData, 18'h2ABCD);
      @(negedge i_clock);
      chk("mid_wen_off", o_wEn, 0);
      chk("mid_wdata_hold", o_wData, 18'h2ABCD);
      send(8'h65);
      chk("mid_done", o_done, 1);
      chk("mid_hold", o_cpuHold, 0);
      chk("mid_count", o_count, 1);
      chk("mid_nwrites", nwr - base, 1);

      // reset after the second word aborts the load
      pulse_start();
      send(8'h00); send(8'h05);
      send(8'h01); send(8'h00); send(8'h01);
      send(8'h02); send(8'hAB); send(8'hCD);
      @(negedge i_clock);
      chk("rst2_count_pre", o_count, 2);
      i_reset = 1'b1;
      i_byte = 8'h00;
      i_byteValid = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      base = nwr;
      repeat (10) @(negedge i_clock);
      i_byteValid = 1'b0;
      chk("rst2_writes", nwr - base, 0);
      chk("rst2_ready", o_byteReady, 0);
      chk("rst2_hold", o_cpuHold, 1);
      chk("rst2_count", o_count, 0);
      chk("rst2_waddr", o_wAddr, 0);
      chk("rst2_done", o_done, 0);
      chk("rst2_error", o_error, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
